riscv_decode_stage: RTL and testbench

//  Instruction decode stage directly upstream of riscv_reg_file. Accepts fetched RV32I

---
 rtl/riscv_decode_stage.sv | 172 +++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - RV32I decode stage: one-entry pipeline register with stall/flush; RISCV_BYPASS_EN adds writeback bypass capture
module riscv_decode_stage #(
  parameter int BUS_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic                      i_VALID,
  output logic                      o_READY,
  input  logic [BUS_WIDTH-1:0]      i_INSTR,
  input  logic [BUS_WIDTH-1:0]      i_PC,
  input  logic                      i_FLUSH,
  output logic [REG_ADDR_WIDTH-1:0] o_RR1,
  output logic [REG_ADDR_WIDTH-1:0] o_RR2,
  output logic                      o_VALID,
  input  logic                      i_READY,
  output logic [BUS_WIDTH-1:0]      o_PC,
  output logic [REG_ADDR_WIDTH-1:0] o_RD,
  output logic [BUS_WIDTH-1:0]      o_IMM,
  output logic [2:0]                o_FUNCT3,
  output logic                      o_FUNCT7B5,
  output logic [3:0]                o_OPCLASS,
  output logic                      o_REG_WRITE,
`ifdef RISCV_BYPASS_EN
  output logic                      o_BYP1,
  output logic                      o_BYP2,
  output logic [BUS_WIDTH-1:0]      o_BYPDATA1,
  output logic [BUS_WIDTH-1:0]      o_BYPDATA2,
  input  logic                      i_WB_EN,
  input  logic [REG_ADDR_WIDTH-1:0] i_WB_RD,
  input  logic [BUS_WIDTH-1:0]      i_WB_DATA,
`endif
  output logic                      o_ILLEGAL
);

  localparam logic [3:0] CLS_OP      = 4'd0;
  localparam logic [3:0] CLS_OPIMM   = 4'd1;
  localparam logic [3:0] CLS_LOAD    = 4'd2;
  localparam logic [3:0] CLS_STORE   = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_JAL     = 4'd5;
  localparam logic [3:0] CLS_JALR    = 4'd6;
  localparam logic [3:0] CLS_LUI     = 4'd7;
  localparam logic [3:0] CLS_AUIPC   = 4'd8;
  localparam logic [3:0] CLS_SYSTEM  = 4'd9;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  logic                      accept;
  logic                      sign;
  logic [3:0]                dec_cls;
  logic [BUS_WIDTH-1:0]      dec_imm;
  logic                      dec_rw;
  logic [REG_ADDR_WIDTH-1:0] rs1_in;
  logic [REG_ADDR_WIDTH-1:0] rs2_in;
  logic [REG_ADDR_WIDTH-1:0] rd_in;
  // Only the rs fields of the held instruction are ever read; reset value matches a NOP (both 0)
  logic [REG_ADDR_WIDTH-1:0] held_rs1;
  logic [REG_ADDR_WIDTH-1:0] held_rs2;

  assign o_READY = !o_VALID || i_READY;
  assign accept  = i_VALID && o_READY && !i_FLUSH;
  assign rs1_in  = i_INSTR[19:15];
  assign rs2_in  = i_INSTR[24:20];
  assign rd_in   = i_INSTR[11:7];
  assign sign    = i_INSTR[31];

  assign o_RR1 = accept ? rs1_in : held_rs1;
  assign o_RR2 = accept ? rs2_in : held_rs2;

  always_comb begin
    dec_cls = CLS_ILLEGAL;
    dec_imm = '0;
    if (i_INSTR[1:0] == 2'b11) begin
      case (i_INSTR[6:2])
        5'b01100: dec_cls = CLS_OP;
        5'b00100: begin
          dec_cls = CLS_OPIMM;
          dec_imm = {{20{sign}}, i_INSTR[31:20]};
        end
        5'b00000: begin
          dec_cls = CLS_LOAD;
          dec_imm = {{20{sign}}, i_INSTR[31:20]};
        end
        5'b01000: begin
          dec_cls = CLS_STORE;
          dec_imm = {{20{sign}}, i_INSTR[31:25], i_INSTR[11:7]};
        end
        5'b11000: begin
          dec_cls = CLS_BRANCH;
          dec_imm = {{19{sign}}, i_INSTR[31], i_INSTR[7], i_INSTR[30:25], i_INSTR[11:8], 1'b0};
        end
        5'b11011: begin
          dec_cls = CLS_JAL;
          dec_imm = {{11{sign}}, i_INSTR[31], i_INSTR[19:12], i_INSTR[20], i_INSTR[30:21], 1'b0};
        end
        5'b11001: begin
          dec_cls = CLS_JALR;
          dec_imm = {{20{sign}}, i_INSTR[31:20]};
        end
        5'b01101: begin
          dec_cls = CLS_LUI;
          dec_imm = {i_INSTR[31:12], 12'b0};
        end
        5'b00101: begin
          dec_cls = CLS_AUIPC;
          dec_imm = {i_INSTR[31:12], 12'b0};
        end
        5'b11100: dec_cls = CLS_SYSTEM;
        default:  dec_cls = CLS_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    dec_rw = 1'b0;
    case (dec_cls)
      CLS_OP, CLS_OPIMM, CLS_LOAD, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC:
        dec_rw = (rd_in != '0);
      default: dec_rw = 1'b0;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_VALID     <= 1'b0;
      o_PC        <= '0;
      o_RD        <= '0;
      o_IMM       <= '0;
      o_FUNCT3    <= '0;
      o_FUNCT7B5  <= 1'b0;
      o_OPCLASS   <= '0;
      o_REG_WRITE <= 1'b0;
      o_ILLEGAL   <= 1'b0;
      held_rs1    <= '0;
      held_rs2    <= '0;
`ifdef RISCV_BYPASS_EN
      o_BYP1      <= 1'b0;
      o_BYP2      <= 1'b0;
      o_BYPDATA1  <= '0;
      o_BYPDATA2  <= '0;
`endif
    end else if (accept) begin
      o_VALID     <= 1'b1;
      o_PC        <= i_PC;
      o_RD        <= rd_in;
      o_IMM       <= dec_imm;
      o_FUNCT3    <= i_INSTR[14:12];
      o_FUNCT7B5  <= i_INSTR[30];
      o_OPCLASS   <= dec_cls;
      o_REG_WRITE <= dec_rw;
      o_ILLEGAL   <= (dec_cls == CLS_ILLEGAL);
      held_rs1    <= rs1_in;
      held_rs2    <= rs2_in;
`ifdef RISCV_BYPASS_EN
      o_BYP1      <= i_WB_EN && (i_WB_RD != '0) && (i_WB_RD == rs1_in);
      o_BYP2      <= i_WB_EN && (i_WB_RD != '0) && (i_WB_RD == rs2_in);
      o_BYPDATA1  <= i_WB_DATA;
      o_BYPDATA2  <= i_WB_DATA;
`endif
    end else begin
      if (i_FLUSH || i_READY) o_VALID <= 1'b0;
`ifdef RISCV_BYPASS_EN
      // While stalled the reg file read has caught up with the write, so the bypass is stale
      if (!i_READY) begin
        o_BYP1 <= 1'b0;
        o_BYP2 <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb/tb_riscv_decode_stage.sv - vector table, handshake sequences and randomized model check for riscv_decode_stage
module tb_riscv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        vin;
  logic        rdy_out;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic [4:0]  rr1, rr2;
  logic        vout;
  logic        rdy_in;
  logic [31:0] pc_out;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [2:0]  funct3;
  logic        f7b5;
  logic [3:0]  cls;
  logic        rw;
  logic        ill;
`ifdef RISCV_BYPASS_EN
  logic        byp1, byp2, wb_en;
  logic [31:0] bypd1, bypd2, wb_data;
  logic [4:0]  wb_rd;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_decode_stage dut (
    .i_CLK(clk), .i_RST(rst), .i_VALID(vin), .o_READY(rdy_out),
    .i_INSTR(instr), .i_PC(pc), .i_FLUSH(flush),
    .o_RR1(rr1), .o_RR2(rr2), .o_VALID(vout), .i_READY(rdy_in),
    .o_PC(pc_out), .o_RD(rd), .o_IMM(imm), .o_FUNCT3(funct3),
    .o_FUNCT7B5(f7b5), .o_OPCLASS(cls), .o_REG_WRITE(rw),
`ifdef RISCV_BYPASS_EN
    .o_BYP1(byp1), .o_BYP2(byp2), .o_BYPDATA1(bypd1), .o_BYPDATA2(bypd2),
    .i_WB_EN(wb_en), .i_WB_RD(wb_rd), .i_WB_DATA(wb_data),
`endif
    .o_ILLEGAL(ill)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        rw;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        rw;
  } bundle_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode from the ISA rules, immediates built by weighted bit sums
  function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] p);
    bundle_t b;
    int v;
    logic writes;
    b.pc = p; b.instr = ins; b.imm = 32'h0; writes = 1'b0;
    v = -int'(ins[31]);
    case (ins[6:0])
      7'h33: begin b.cls = 4'd0; writes = 1'b1; end
      7'h13: begin b.cls = 4'd1; writes = 1'b1; b.imm = 32'(v * 2048 + int'(ins[30:20])); end
      7'h03: begin b.cls = 4'd2; writes = 1'b1; b.imm = 32'(v * 2048 + int'(ins[30:20])); end
      7'h23: begin b.cls = 4'd3; b.imm = 32'(v * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7])); end
      7'h63: begin b.cls = 4'd4;
        b.imm = 32'(v * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2); end
      7'h6F: begin b.cls = 4'd5; writes = 1'b1;
        b.imm = 32'(v * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2); end
      7'h67: begin b.cls = 4'd6; writes = 1'b1; b.imm = 32'(v * 2048 + int'(ins[30:20])); end
      7'h37: begin b.cls = 4'd7; writes = 1'b1; b.imm = ins & 32'hFFFFF000; end
      7'h17: begin b.cls = 4'd8; writes = 1'b1; b.imm = ins & 32'hFFFFF000; end
      7'h73: b.cls = 4'd9;
      default: b.cls = 4'd15;
    endcase
    b.rw = writes && (ins[11:7] != 5'd0);
    return b;
  endfunction

  task automatic chk_bundle(input string tag, input bundle_t b);
    chk({tag, ".valid"}, 32'(vout), 32'd1);
    chk({tag, ".pc"}, pc_out, b.pc);
    chk({tag, ".rd"}, 32'(rd), 32'(b.instr[11:7]));
    chk({tag, ".imm"}, imm, b.imm);
    chk({tag, ".funct3"}, 32'(funct3), 32'(b.instr[14:12]));
    chk({tag, ".f7b5"}, 32'(f7b5), 32'(b.instr[30]));
    chk({tag, ".cls"}, 32'(cls), 32'(b.cls));
    chk({tag, ".rw"}, 32'(rw), 32'(b.rw));
    chk({tag, ".ill"}, 32'(ill), 32'(b.cls == 4'd15));
  endtask

  task automatic do_reset();
    rst = 1'b1; vin = 1'b0; flush = 1'b0; rdy_in = 1'b1; instr = 32'h0; pc = 32'h0;
`ifdef RISCV_BYPASS_EN
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t    vt[$];
  bundle_t mb;
  bundle_t hold_b;
  logic    m_valid;
  logic [4:0] m_rs1, m_rs2;
  logic    m_acc;

  initial begin
    vt.push_back('{32'h00500093, 4'd1,  32'h00000005, 1'b1}); // addi x1,x0,5
    vt.push_back('{32'h0020A423, 4'd3,  32'h00000008, 1'b0}); // sw x2,8(x1)
    vt.push_back('{32'hFE20AE23, 4'd3,  32'hFFFFFFFC, 1'b0}); // sw x2,-4(x1)
    vt.push_back('{32'hFE208EE3, 4'd4,  32'hFFFFFFFC, 1'b0}); // beq x1,x2,-4
    vt.push_back('{32'h0000006F, 4'd5,  32'h00000000, 1'b0}); // jal x0,0
    vt.push_back('{32'h008000EF, 4'd5,  32'h00000008, 1'b1}); // jal x1,8
    vt.push_back('{32'hFFFFFFFF, 4'd15, 32'h00000000, 1'b0});
    vt.push_back('{32'h00500090, 4'd15, 32'h00000000, 1'b0}); // instr[1:0]!=11
    vt.push_back('{32'h123450B7, 4'd7,  32'h12345000, 1'b1}); // lui x1
    vt.push_back('{32'h00001117, 4'd8,  32'h00001000, 1'b1}); // auipc x2,1
    vt.push_back('{32'hFF8280E7, 4'd6,  32'hFFFFFFF8, 1'b1}); // jalr x1,-8(x5)
    vt.push_back('{32'h002081B3, 4'd0,  32'h00000000, 1'b1}); // add x3,x1,x2
    vt.push_back('{32'h00000073, 4'd9,  32'h00000000, 1'b0}); // ecall
    vt.push_back('{32'h0040A003, 4'd2,  32'h00000004, 1'b0}); // lw x0,4(x1)

    do_reset();
    chk("rst.valid", 32'(vout), 32'd0);
    chk("rst.ready", 32'(rdy_out), 32'd1);
    chk("rst.rr1", 32'(rr1), 32'd0);
    chk("rst.rr2", 32'(rr2), 32'd0);
    chk("rst.pc", pc_out, 32'd0);
    chk("rst.imm", imm, 32'd0);
    chk("rst.cls", 32'(cls), 32'd0);
    chk("rst.fields", {26'd0, rd, rw}, 32'd0);
    chk("rst.misc", {27'd0, funct3, f7b5, ill}, 32'd0);

    // Table: back-to-back accepts with execute always ready
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      vin = 1'b1; instr = vt[i].instr; pc = 32'h1000 + 32'(i) * 4;
      #1;
      chk("tbl.rr1", 32'(rr1), 32'(vt[i].instr[19:15]));
      chk("tbl.rr2", 32'(rr2), 32'(vt[i].instr[24:20]));
      @(posedge clk); #1;
      chk_bundle("tbl", '{32'h1000 + 32'(i) * 4, vt[i].instr, vt[i].cls, vt[i].imm, vt[i].rw});
    end
    @(negedge clk); vin = 1'b0;
    @(negedge clk);
    chk("handoff.valid", 32'(vout), 32'd0);

    // Stall: beq held for 3 cycles while another instruction is offered
    vin = 1'b1; instr = 32'hFE208EE3; pc = 32'h2000; rdy_in = 1'b0;
    @(negedge clk);
    instr = 32'h00500093; pc = 32'h2004;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall.ready", 32'(rdy_out), 32'd0);
      chk("stall.rr1", 32'(rr1), 32'd1);
      chk("stall.rr2", 32'(rr2), 32'd2);
      chk_bundle("stall", '{32'h2000, 32'hFE208EE3, 4'd4, 32'hFFFFFFFC, 1'b0});
      @(negedge clk);
    end
    rdy_in = 1'b1; vin = 1'b0;
    @(negedge clk);
    chk("unstall.valid", 32'(vout), 32'd0);

    // Flush with a pending bundle and a valid incoming instruction
    vin = 1'b1; instr = 32'h0000006F; pc = 32'h3000; rdy_in = 1'b0;
    @(negedge clk);
    chk_bundle("jal", '{32'h3000, 32'h0000006F, 4'd5, 32'h0, 1'b0});
    flush = 1'b1; instr = 32'h00500093;
    @(negedge clk);
    flush = 1'b0; vin = 1'b0; rdy_in = 1'b1;
    chk("flush.valid", 32'(vout), 32'd0);
    chk("flush.pc", pc_out, 32'h3000);

    // Reset in the middle of a transfer
    vin = 1'b1; instr = 32'h002081B3; pc = 32'h4000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; vin = 1'b0;
    #1;
    chk("midrst.valid", 32'(vout), 32'd0);
    chk("midrst.pc", pc_out, 32'd0);
    chk("midrst.rr1", 32'(rr1), 32'd0);

`ifdef RISCV_BYPASS_EN
    @(negedge clk);
    vin = 1'b1; instr = 32'h002081B3; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("byp.b1", 32'(byp1), 32'd1);
    chk("byp.d1", bypd1, 32'hDEADBEEF);
    chk("byp.b2", 32'(byp2), 32'd0);
    wb_rd = 5'd0;
    @(negedge clk);
    chk("byp.x0", {30'd0, byp1, byp2}, 32'd0);
    vin = 1'b0; wb_en = 1'b0;
    @(negedge clk);
`endif

    // Randomized handshake traffic against the transaction-level model
    do_reset();
    m_valid = 1'b0; m_rs1 = 5'd0; m_rs2 = 5'd0;
    hold_b = model(32'h00000013, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      int sel;
      logic [6:0] ops[10];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
      @(negedge clk);
      r = $urandom();
      sel = $urandom_range(0, 10);
      instr = (sel == 10) ? r : {r[31:7], ops[sel]};
      pc = $urandom();
      vin = ($urandom_range(0, 9) < 7);
      rdy_in = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      #1;
      m_acc = vin && (!m_valid || rdy_in) && !flush;
      chk("rnd.ready", 32'(rdy_out), 32'(!m_valid || rdy_in));
      chk("rnd.rr1", 32'(rr1), 32'(m_acc ? instr[19:15] : m_rs1));
      chk("rnd.rr2", 32'(rr2), 32'(m_acc ? instr[24:20] : m_rs2));
      chk("rnd.valid", 32'(vout), 32'(m_valid));
      if (m_valid) chk_bundle("rnd", hold_b);
      @(posedge clk);
      if (m_acc) begin
        mb = model(instr, pc);
        hold_b = mb; m_valid = 1'b1; m_rs1 = instr[19:15]; m_rs2 = instr[24:20];
      end else if (flush || rdy_in) begin
        m_valid = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
